conv_row_scheduler: RTL and testbench

CONV_ROW_SCHEDULER -- requirements
Module: conv_row_scheduler

---
 rtl/conv_row_scheduler_pkg.sv | 21 ++
 rtl/conv_row_scheduler_if.sv | 25 ++
 rtl/conv_row_scheduler_rcc_counter.sv | 70 +++++++
 rtl/conv_row_scheduler.sv | 112 +++++++++++
 tb/tb_conv_row_scheduler.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_row_scheduler_pkg.sv
// rtl/conv_row_scheduler_pkg.sv - shared state type, field indices and ceil helper
package conv_row_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BANK,
      ISSUE,
      SWITCH,
      FINISH
   } state_e;

   localparam int ROW_IDX = 2;
   localparam int COL_IDX = 1;
   localparam int CH_IDX  = 0;

   // Rounds a up to the next multiple of b.
   function automatic int ceil(input int a, input int b);
      return ((a + b - 1) / b) * b;
   endfunction

endpackage

// File: rtl/conv_row_scheduler_if.sv
// rtl/conv_row_scheduler_if.sv - handshake bundle between row scheduler and its controller
interface conv_row_scheduler_if #(
   parameter int ROW_WIDTH = 10
) ();

   logic                      start;
   logic                      row_loaded;
   logic                      row_ready;
   logic [2:0][ROW_WIDTH-1:0] R_C_Channel;
   logic                      row_valid;
   logic                      row_RAM_switch;
   logic                      busy;
   logic                      done;

   modport master (
      output start, row_loaded, row_ready,
      input  R_C_Channel, row_valid, row_RAM_switch, busy, done
   );

   modport slave (
      input  start, row_loaded, row_ready,
      output R_C_Channel, row_valid, row_RAM_switch, busy, done
   );

endinterface

// File: rtl/conv_row_scheduler_rcc_counter.sv
// rtl/conv_row_scheduler_rcc_counter.sv - nested row/tile/channel wrapping counter
module rcc_counter #(
   parameter int W      = 10,
   parameter int CH_N   = 64,
   parameter int TILE_N = 2,
   parameter int ROW_N  = 56
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         adv_inner,
   input  logic         adv_row,
   output logic [W-1:0] row,
   output logic [W-1:0] tile,
   output logic [W-1:0] ch,
   output logic         inner_last,
   output logic         row_last
);

   localparam logic [W-1:0] CH_LAST   = W'(CH_N - 1);
   localparam logic [W-1:0] TILE_LAST = W'(TILE_N - 1);
   localparam logic [W-1:0] ROW_LAST  = W'(ROW_N - 1);

   logic [W-1:0] row_d, row_q;
   logic [W-1:0] tile_d, tile_q;
   logic [W-1:0] ch_d, ch_q;

   always_comb begin
      row_d  = row_q;
      tile_d = tile_q;
      ch_d   = ch_q;
      if (clear) begin
         row_d  = '0;
         tile_d = '0;
         ch_d   = '0;
      end else begin
         // Channel is the fastest digit; a channel wrap carries into the tile.
         if (adv_inner) begin
            if (ch_q == CH_LAST) begin
               ch_d   = '0;
               tile_d = (tile_q == TILE_LAST) ? '0 : tile_q + 1'b1;
            end else begin
               ch_d = ch_q + 1'b1;
            end
         end
         if (adv_row) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q  <= '0;
         tile_q <= '0;
         ch_q   <= '0;
      end else begin
         row_q  <= row_d;
         tile_q <= tile_d;
         ch_q   <= ch_d;
      end
   end

   assign row        = row_q;
   assign tile       = tile_q;
   assign ch         = ch_q;
   assign inner_last = (ch_q == CH_LAST) && (tile_q == TILE_LAST);
   assign row_last   = (row_q == ROW_LAST);

endmodule

// File: rtl/conv_row_scheduler.sv
// rtl/conv_row_scheduler.sv - walks output rows, column tiles and channels for one conv layer
module conv_row_scheduler
   import conv_row_scheduler_pkg::*;
#(
   parameter int REAL_HOUT = 56,
   parameter int NEXT_Iw   = 45,
   parameter int NEXT_C    = 64,
   parameter int ROW_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rstn,
   conv_row_scheduler_if.slave  bus
);

   localparam int COL_TILES = ceil(REAL_HOUT, NEXT_Iw) / NEXT_Iw;
   localparam logic [ROW_WIDTH-1:0] IW_W = ROW_WIDTH'(NEXT_Iw);

   state_e state_d, state_q;

   logic                 cnt_clear;
   logic                 adv_inner;
   logic                 adv_row;
   logic                 inner_last;
   logic                 row_last;
   logic [ROW_WIDTH-1:0] row_cnt;
   logic [ROW_WIDTH-1:0] tile_cnt;
   logic [ROW_WIDTH-1:0] ch_cnt;

   rcc_counter #(
      .W      (ROW_WIDTH),
      .CH_N   (NEXT_C),
      .TILE_N (COL_TILES),
      .ROW_N  (REAL_HOUT)
   ) u_rcc_counter (
      .clk        (clk),
      .rst        (rstn),
      .clear      (cnt_clear),
      .adv_inner  (adv_inner),
      .adv_row    (adv_row),
      .row        (row_cnt),
      .tile       (tile_cnt),
      .ch         (ch_cnt),
      .inner_last (inner_last),
      .row_last   (row_last)
   );

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      cnt_clear          = 1'b0;
      adv_inner          = 1'b0;
      adv_row            = 1'b0;
      bus.row_valid      = 1'b0;
      bus.row_RAM_switch = 1'b0;
      bus.done           = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_clear = 1'b1;
               state_d   = WAIT_BANK;
            end
         end
         WAIT_BANK: begin
            if (bus.row_loaded) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            bus.row_valid = 1'b1;
            if (bus.row_ready) begin
               adv_inner = 1'b1;
               if (inner_last) begin
                  state_d = SWITCH;
               end
            end
         end
         SWITCH: begin
            bus.row_RAM_switch = 1'b1;
            if (row_last) begin
               state_d = FINISH;
            end else begin
               adv_row = 1'b1;
               state_d = WAIT_BANK;
            end
         end
         FINISH: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy = (state_q != IDLE);

   always_comb begin
      bus.R_C_Channel          = '0;
      bus.R_C_Channel[ROW_IDX] = row_cnt;
      bus.R_C_Channel[COL_IDX] = tile_cnt * IW_W;
      bus.R_C_Channel[CH_IDX]  = ch_cnt;
   end

endmodule

// File: tb/tb_conv_row_scheduler.sv
// tb/tb_conv_row_scheduler.sv - scoreboard bench for conv_row_scheduler
module tb_conv_row_scheduler;

   localparam int RW    = 10;
   localparam int H     = 4;
   localparam int IW    = 3;
   localparam int C     = 2;
   localparam int COLS  = (H + IW - 1) / IW;
   localparam int DH    = 56;
   localparam int DIW   = 45;
   localparam int DC    = 64;

   logic clk = 1'b0;
   logic rst;
   logic rst_d;

   always #5 clk = ~clk;

   conv_row_scheduler_if #(.ROW_WIDTH(RW)) bus ();
   conv_row_scheduler_if #(.ROW_WIDTH(RW)) bus_d ();

   conv_row_scheduler #(
      .REAL_HOUT (H),
      .NEXT_Iw   (IW),
      .NEXT_C    (C),
      .ROW_WIDTH (RW)
   ) dut (
      .clk  (clk),
      .rstn (rst),
      .bus  (bus)
   );

   conv_row_scheduler #(
      .REAL_HOUT (DH),
      .NEXT_Iw   (DIW),
      .NEXT_C    (DC),
      .ROW_WIDTH (RW)
   ) dut_d (
      .clk  (clk),
      .rstn (rst_d),
      .bus  (bus_d)
   );

   int checks = 0;
   int errors = 0;

   logic [3*RW-1:0] exp_q[$];
   logic [3*RW-1:0] exp_d[$];

   int mode = 0;
   int n_xfer = 0, n_sw = 0, n_done = 0, last_row = 0;
   int nd_xfer = 0, nd_sw = 0, nd_done = 0;
   logic [3*RW-1:0] last_d = '0;
   bit def_finished = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Reference model: rows outermost, then column tiles, then channels.
   task automatic push_layer(input int hh, input int iw, input int cc, input bit dflt);
      int cols;
      cols = (hh + iw - 1) / iw;
      for (int r = 0; r < hh; r++)
         for (int t = 0; t < cols; t++)
            for (int c = 0; c < cc; c++)
               if (dflt) exp_d.push_back({RW'(r), RW'(t * iw), RW'(c)});
               else      exp_q.push_back({RW'(r), RW'(t * iw), RW'(c)});
   endtask

   // Input driver: row_ready pattern by mode; mode 2 delays row_loaded 10 cycles per row.
   initial begin
      int gap;
      gap = 0;
      bus.row_ready  = 1'b0;
      bus.row_loaded = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0:       bus.row_ready = 1'b1;
            1:       bus.row_ready = ~bus.row_ready;
            default: bus.row_ready = 1'($urandom_range(0, 1));
         endcase
         if (mode == 2) begin
            if (!bus.busy || bus.row_valid) begin
               bus.row_loaded = 1'b0;
               gap = 0;
            end else if (gap >= 10) begin
               bus.row_loaded = 1'b1;
            end else begin
               gap++;
            end
         end else begin
            bus.row_loaded = 1'b1;
         end
      end
   end

   // Monitor for the small instance.
   initial begin
      logic [3*RW-1:0] prev_rcc, exp;
      logic prev_valid, prev_ready, prev_loaded, prev2_loaded;
      prev_rcc = '0; prev_valid = 0; prev_ready = 0; prev_loaded = 0; prev2_loaded = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 0; prev_loaded = 0; prev2_loaded = 0;
         end else begin
            if (bus.row_valid && bus.row_ready) begin
               if (exp_q.size() == 0) flag_fail("xfer_unexpected");
               else begin
                  exp = exp_q.pop_front();
                  check("xfer", bus.R_C_Channel, exp);
               end
               n_xfer++;
               last_row = int'(bus.R_C_Channel[2]);
            end
            if (prev_valid && !prev_ready && bus.row_valid)
               check("hold_stable", bus.R_C_Channel, prev_rcc);
            if (bus.row_RAM_switch) begin
               n_sw++;
               check("valid_in_switch", bus.row_valid, 0);
            end
            if (bus.done) begin
               n_done++;
               check("busy_at_done", bus.busy, 1);
               check("valid_at_done", bus.row_valid, 0);
            end
            if (mode == 2 && bus.row_valid && !prev_valid) begin
               check("loaded_then_valid", prev_loaded, 1);
               check("valid_not_early", prev2_loaded, 0);
            end
            prev_rcc     = bus.R_C_Channel;
            prev_valid   = bus.row_valid;
            prev_ready   = bus.row_ready;
            prev2_loaded = prev_loaded;
            prev_loaded  = bus.row_loaded;
         end
      end
   end

   // Monitor for the default-parameter instance.
   initial begin
      logic [3*RW-1:0] exp;
      forever begin
         @(negedge clk);
         if (!rst_d) begin
            if (bus_d.row_valid && bus_d.row_ready) begin
               if (exp_d.size() == 0) flag_fail("def_xfer_unexpected");
               else begin
                  exp = exp_d.pop_front();
                  check("def_xfer", bus_d.R_C_Channel, exp);
               end
               nd_xfer++;
               last_d = bus_d.R_C_Channel;
            end
            if (bus_d.row_RAM_switch) nd_sw++;
            if (bus_d.done) nd_done++;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int cyc;
      cyc = 0;
      while (n_done == d0 && cyc < 3000) begin
         @(posedge clk);
         cyc++;
      end
      if (n_done == d0) flag_fail(name);
   endtask

   task automatic wait_row(input int x0, input int row);
      int cyc;
      cyc = 0;
      while (!(n_xfer > x0 && last_row == row) && cyc < 3000) begin
         @(posedge clk);
         cyc++;
      end
      if (cyc >= 3000) flag_fail("wait_row_timeout");
   endtask

   task automatic run_layer(input int m, input bit restart);
      int d0, s0, x0;
      mode = m;
      d0 = n_done; s0 = n_sw; x0 = n_xfer;
      push_layer(H, IW, C, 1'b0);
      pulse_start();
      check("busy_after_start", bus.busy, 1);
      if (restart) begin
         wait_row(x0, 2);
         pulse_start();
      end
      wait_done(d0, "done_timeout");
      #1;
      check("busy_after_done", bus.busy, 0);
      repeat (2) @(posedge clk);
      check("done_count", n_done - d0, 1);
      check("switch_count", n_sw - s0, H);
      check("xfer_count", n_xfer - x0, H * COLS * C);
      check("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      int d0, x0, cyc;
      rst = 1'b1; rst_d = 1'b1;
      bus.start = 1'b0;
      bus_d.start = 1'b0; bus_d.row_loaded = 1'b1; bus_d.row_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", bus.row_valid, 0);
      check("rst_switch", bus.row_RAM_switch, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_rcc", bus.R_C_Channel, 0);
      rst = 1'b0; rst_d = 1'b0;

      fork
         begin
            int dc;
            push_layer(DH, DIW, DC, 1'b1);
            @(posedge clk); #1 bus_d.start = 1'b1;
            @(posedge clk); #1 bus_d.start = 1'b0;
            dc = 0;
            while (nd_done == 0 && dc < 12000) begin
               @(posedge clk);
               dc++;
            end
            if (nd_done == 0) flag_fail("def_done_timeout");
            @(posedge clk); #1;
            check("def_xfer_count", nd_xfer, 7168);
            check("def_switch_count", nd_sw, 56);
            check("def_done_count", nd_done, 1);
            check("def_last", last_d, {10'd55, 10'd45, 10'd63});
            check("def_queue_empty", exp_d.size(), 0);
            def_finished = 1'b1;
         end
      join_none

      run_layer(0, 1'b0);
      run_layer(1, 1'b0);
      run_layer(2, 1'b0);
      run_layer(3, 1'b1);
      run_layer(3, 1'b0);

      // Abort a layer during row 1 with reset.
      mode = 0;
      d0 = n_done; x0 = n_xfer;
      push_layer(H, IW, C, 1'b0);
      pulse_start();
      wait_row(x0, 1);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("abort_valid", bus.row_valid, 0);
      check("abort_switch", bus.row_RAM_switch, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_rcc", bus.R_C_Channel, 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", n_done - d0, 0);
      check("abort_idle", bus.busy, 0);
      run_layer(0, 1'b0);

      cyc = 0;
      while (!def_finished && cyc < 12000) begin
         @(posedge clk);
         cyc++;
      end
      if (!def_finished) flag_fail("def_finish_timeout");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
